if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS32 pipeline. It is the producer end of the IF/ID interface.
- Owns the PC register and drives the synchronous instruction ROM.
- Registers PC, PC+4, delay-slot flag and fetch exception code into the IF/ID boundary.
- Consumes the redirect outputs from decode (jtsel, jump addresses, next-delay flag) and the redirect address from CP0/exception logic.

Parameters:
RESET_PC, 32'hBFC00000, PC value loaded on reset.
EXC_NONE, 5'h10, exception code meaning "no exception".
EXC_ADEL, 5'h04, exception code for a misaligned fetch address.

Ports:
cpu_clk_50M  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall_if  in  1  hold PC, no new fetch
stall_id  in  1  hold IF/ID register; stall_id=1 always comes with stall_if=1
flush  in  1  exception/eret flush; redirect to cp0_excaddr
cp0_excaddr  in  32  exception handler or EPC target
jtsel  in  2  00 seq, 01 jump_addr_1 (j/jal), 10 jump_addr_3 (jr), 11 jump_addr_2 (taken branch)
jump_addr_1  in  32  j/jal target
jump_addr_2  in  32  branch target
jump_addr_3  in  32  jr target
next_delay_i  in  1  instruction now in ID is a branch/jump
ice  out  1  instruction ROM read enable
iaddr  out  32  instruction ROM address (= pc)
inst_rdata  in  32  ROM data, big-endian byte order, valid the cycle after an ice=1 edge
id_inst_o  out  32  raw instruction to ID, not byte-swapped
id_pc_o  out  32  PC of id_inst_o
id_pc_plus_4_o  out  32  id_pc_o+4
id_valid_o  out  1  IF/ID slot holds a real instruction
id_in_delay_o  out  1  ID instruction is a delay slot
flush_im_o  out  1  tells ID to squash its instruction (= ~id_valid_o)
if_exccode_o  out  5  fetch exception code for the ID instruction

Behaviour:
- One clock domain (cpu_clk_50M); reset is synchronous and active-high (rst).
- Reset edge:
  - pc=RESET_PC.
  - id_pc_o=0, id_pc_plus_4_o=0, id_valid_o=0, id_in_delay_o=0, if_exccode_o=EXC_NONE.
  - hold buffer empty; id_inst_o=0; flush_im_o=1.
  - While rst=1: ice=0.
- Next-PC priority, evaluated at each edge:
  - flush: cp0_excaddr
  - else stall_if: pc held
  - else by jtsel: 01 jump_addr_1; 10 jump_addr_3; 11 jump_addr_2; 00 pc+4 (mod 2^32)
- ice = ~rst & ~stall_if & (pc[1:0]==0). iaddr=pc always.
- IF/ID register, next state at each edge:
  - flush: valid=0, in_delay=0, exccode=EXC_NONE, pc fields=0.
  - else stall_id: all fields held.
  - else stall_if (without stall_id): bubble, valid=0.
  - else: pc fields <= pc / pc+4; valid=1; in_delay <= next_delay_i; exccode <= misaligned ? EXC_ADEL : EXC_NONE.
- Delay slot: no squash on redirect. The instruction fetched in the same cycle the branch is in ID proceeds with id_in_delay_o=1.
- Instruction path, 1-cycle ROM latency:
  - id_inst_o = 0 when id_valid_o=0 or the ID exception is EXC_ADEL.
  - else id_inst_o = hold buffer if full, else inst_rdata.
- Hold buffer, for ROMs that do not hold output while ice=0:
  - Edge with stall_id=1 and buffer empty: capture the current id_inst_o; buffer full.
  - Edge with stall_id=0 or flush: buffer empty.
  - Stall of any length returns the same instruction every cycle.
- Flush:
  - Cycle after a flush edge: id_valid_o=0, flush_im_o=1. The stale ROM word is discarded.
  - Next edge: pc=cp0_excaddr is registered into ID with valid=1 and in_delay=0.
- Simultaneous events:
  - flush beats stall_if and stall_id.
  - stall_if beats jtsel; decode re-presents the redirect after the stall.
  - Reset beats everything.
- Reset asserted mid-stall or mid-flush: reset state on the next edge, hold buffer cleared.
- Misaligned pc:
  - ice=0; the ID slot gets valid=1, exccode=EXC_ADEL, instruction 0.
  - pc keeps advancing until flush.

Test Plan:
- Release rst: iaddr=BFC00000 in cycle 1; then id_pc_o=BFC00000, id_valid_o=1. Next cycle id_pc_o=BFC00004, id_pc_plus_4_o=BFC00008. Cycle 1: id_inst_o=0, flush_im_o=1.
- Sequential ROM word 0x0000083C at BFC00000: id_inst_o=0x0000083C unswapped, exccode=10.
- Branch in ID at pc BFC00010 (next_delay_i=1, jtsel=11, jump_addr_2=BFC00100):
  - BFC00014 enters ID with id_in_delay_o=1.
  - The following ID pc is BFC00100 with in_delay=0.
- stall_if=stall_id=1 for 3 cycles while ROM output is forced to 0xDEADBEEF:
  - id_inst_o holds the original word; id_pc_o is unchanged; ice=0.
  - After release, pc resumes with no skipped or duplicated instruction.
- flush with cp0_excaddr=BFC00380 during a stall:
  - Next cycle id_valid_o=0, flush_im_o=1, hold buffer empty.
  - Then id_pc_o=BFC00380, valid=1.
- jtsel=10, jump_addr_3=BFC00202:
  - ice=0.
  - ID gets pc BFC00202, exccode=04, id_inst_o=0.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction ROM bus between the fetch stage (master) and the synchronous ROM (slave).
interface if_stage_if;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst_rdata;

    modport master (output ice, output iaddr, input inst_rdata);
    modport slave  (input ice, input iaddr, output inst_rdata);
endinterface

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, drives the instruction ROM and
// registers the fetched slot into the IF/ID boundary.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [4:0]  EXC_NONE = 5'h10,
    parameter logic [4:0]  EXC_ADEL = 5'h04
) (
    input  logic        cpu_clk_50M,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] cp0_excaddr,
    input  logic [1:0]  jtsel,
    input  logic [31:0] jump_addr_1,
    input  logic [31:0] jump_addr_2,
    input  logic [31:0] jump_addr_3,
    input  logic        next_delay_i,
    if_stage_if.master  rom,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus_4_o,
    output logic        id_valid_o,
    output logic        id_in_delay_o,
    output logic        flush_im_o,
    output logic [4:0]  if_exccode_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus_4;
    logic        misaligned;

    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        id_delay_q, id_delay_d;
    logic [4:0]  id_exc_q, id_exc_d;

    logic [31:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;

    assign pc_plus_4  = pc_q + 32'd4;
    assign misaligned = (pc_q[1:0] != 2'b00);

    assign rom.iaddr = pc_q;
    assign rom.ice   = ~rst & ~stall_if & ~misaligned;

    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = cp0_excaddr;
        end else if (!stall_if) begin
            unique case (jtsel)
                2'b01:   pc_d = jump_addr_1;
                2'b10:   pc_d = jump_addr_3;
                2'b11:   pc_d = jump_addr_2;
                default: pc_d = pc_plus_4;
            endcase
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        id_delay_d = id_delay_q;
        id_exc_d   = id_exc_q;
        if (flush) begin
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
            id_delay_d = 1'b0;
            id_exc_d   = EXC_NONE;
        end else if (stall_id) begin
            // Slot held as-is; the hold buffer keeps its instruction word.
        end else if (stall_if) begin
            id_valid_d = 1'b0;
            id_delay_d = 1'b0;
            id_exc_d   = EXC_NONE;
        end else begin
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus_4;
            id_valid_d = 1'b1;
            id_delay_d = next_delay_i;
            id_exc_d   = misaligned ? EXC_ADEL : EXC_NONE;
        end
    end

    // The ROM output is only trusted on the cycle after a fetch; during an ID
    // stall the word is parked here so later ROM garbage cannot leak through.
    always_comb begin
        if (!id_valid_q || id_exc_q == EXC_ADEL) begin
            id_inst_o = '0;
        end else if (hold_full_q) begin
            id_inst_o = hold_q;
        end else begin
            id_inst_o = rom.inst_rdata;
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (flush || !stall_id) begin
            hold_full_d = 1'b0;
        end else if (!hold_full_q) begin
            hold_d      = id_inst_o;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_pc4_q    <= '0;
            id_valid_q  <= 1'b0;
            id_delay_q  <= 1'b0;
            id_exc_q    <= EXC_NONE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_valid_q  <= id_valid_d;
            id_delay_q  <= id_delay_d;
            id_exc_q    <= id_exc_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign id_pc_o        = id_pc_q;
    assign id_pc_plus_4_o = id_pc4_q;
    assign id_valid_o     = id_valid_q;
    assign id_in_delay_o  = id_delay_q;
    assign if_exccode_o   = id_exc_q;
    assign flush_im_o     = ~id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a slot-level reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall_if, stall_id, flush, next_delay_i;
    logic [31:0] cp0_excaddr, jump_addr_1, jump_addr_2, jump_addr_3;
    logic [1:0]  jtsel;
    logic [31:0] id_inst_o, id_pc_o, id_pc_plus_4_o;
    logic        id_valid_o, id_in_delay_o, flush_im_o;
    logic [4:0]  if_exccode_o;

    int checks = 0;
    int errors = 0;

    if_stage_if rom_bus ();

    if_stage dut (
        .cpu_clk_50M    (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .flush          (flush),
        .cp0_excaddr    (cp0_excaddr),
        .jtsel          (jtsel),
        .jump_addr_1    (jump_addr_1),
        .jump_addr_2    (jump_addr_2),
        .jump_addr_3    (jump_addr_3),
        .next_delay_i   (next_delay_i),
        .rom            (rom_bus),
        .id_inst_o      (id_inst_o),
        .id_pc_o        (id_pc_o),
        .id_pc_plus_4_o (id_pc_plus_4_o),
        .id_valid_o     (id_valid_o),
        .id_in_delay_o  (id_in_delay_o),
        .flush_im_o     (flush_im_o),
        .if_exccode_o   (if_exccode_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h0000083C;
        return a ^ 32'h5A5A0000;
    endfunction

    // ROM that does not hold its output: anything but a fetch edge yields garbage.
    always @(posedge clk) begin
        rom_bus.inst_rdata <= rom_bus.ice ? rom_word(rom_bus.iaddr) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: architectural PC plus the contents of the ID slot.
    logic [31:0] m_pc, m_id_pc, m_inst;
    logic        m_valid, m_delay, m_ready = 1'b0;
    logic [4:0]  m_exc;

    always @(posedge clk) begin
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (rst) begin
            m_pc = 32'hBFC00000; m_valid = 0; m_id_pc = 0; m_delay = 0;
            m_exc = 5'h10; m_inst = 0; m_ready = 1'b1;
        end else if (m_ready) begin
            if (flush) begin
                m_pc = cp0_excaddr; m_valid = 0; m_id_pc = 0; m_delay = 0;
                m_exc = 5'h10; m_inst = 0;
            end else begin
                if (!stall_id) begin
                    if (stall_if) begin
                        m_valid = 0; m_delay = 0; m_exc = 5'h10; m_inst = 0;
                    end else begin
                        m_valid = 1; m_id_pc = old_pc; m_delay = next_delay_i;
                        m_exc   = (old_pc % 4 == 0) ? 5'h10 : 5'h04;
                        m_inst  = (old_pc % 4 == 0) ? rom_word(old_pc) : 32'd0;
                    end
                end
                if (!stall_if) begin
                    case (jtsel)
                        2'd1:    m_pc = jump_addr_1;
                        2'd2:    m_pc = jump_addr_3;
                        2'd3:    m_pc = jump_addr_2;
                        default: m_pc = old_pc + 32'd4;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("m_iaddr", rom_bus.iaddr, m_pc);
            chk("m_ice", {31'd0, rom_bus.ice},
                {31'd0, !rst && !stall_if && (m_pc % 4 == 0)});
            chk("m_valid", {31'd0, id_valid_o}, {31'd0, m_valid});
            chk("m_flush_im", {31'd0, flush_im_o}, {31'd0, !m_valid});
            chk("m_inst", id_inst_o, m_inst);
            if (m_valid) begin
                chk("m_id_pc", id_pc_o, m_id_pc);
                chk("m_id_pc4", id_pc_plus_4_o, m_id_pc + 32'd4);
                chk("m_delay", {31'd0, id_in_delay_o}, {31'd0, m_delay});
                chk("m_exc", {27'd0, if_exccode_o}, {27'd0, m_exc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall_if = 0; stall_id = 0; flush = 0; next_delay_i = 0;
        cp0_excaddr = 0; jtsel = 0; jump_addr_1 = 0; jump_addr_2 = 0; jump_addr_3 = 0;
        step(); step();
        chk("rst_iaddr", rom_bus.iaddr, 32'hBFC00000);
        chk("rst_ice", {31'd0, rom_bus.ice}, 32'd0);
        chk("rst_flush_im", {31'd0, flush_im_o}, 32'd1);
        chk("rst_exc", {27'd0, if_exccode_o}, 32'h10);

        rst = 0; #1;
        chk("c1_ice", {31'd0, rom_bus.ice}, 32'd1);
        chk("c1_inst", id_inst_o, 32'd0);
        step();
        chk("first_pc", id_pc_o, 32'hBFC00000);
        chk("first_inst", id_inst_o, 32'h0000083C);
        chk("first_valid", {31'd0, id_valid_o}, 32'd1);
        step();
        chk("second_pc", id_pc_o, 32'hBFC00004);
        chk("second_pc4", id_pc_plus_4_o, 32'hBFC00008);
        step(); step(); step();
        chk("branch_id_pc", id_pc_o, 32'hBFC00010);

        // Branch in ID redirects; the already-fetching slot is the delay slot.
        next_delay_i = 1; jtsel = 2'b11; jump_addr_2 = 32'hBFC00100;
        step();
        next_delay_i = 0; jtsel = 2'b00;
        chk("dslot_pc", id_pc_o, 32'hBFC00014);
        chk("dslot_flag", {31'd0, id_in_delay_o}, 32'd1);
        step();
        chk("target_pc", id_pc_o, 32'hBFC00100);
        chk("target_flag", {31'd0, id_in_delay_o}, 32'd0);

        stall_if = 1; stall_id = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_inst", id_inst_o, 32'hE59A0100);
            chk("stall_pc", id_pc_o, 32'hBFC00100);
            chk("stall_ice", {31'd0, rom_bus.ice}, 32'd0);
        end
        stall_if = 0; stall_id = 0;
        step();
        chk("resume_pc", id_pc_o, 32'hBFC00104);
        chk("resume_inst", id_inst_o, 32'hE59A0104);

        // Fetch-only stall inserts a bubble.
        stall_if = 1;
        step();
        stall_if = 0;
        chk("bubble_valid", {31'd0, id_valid_o}, 32'd0);
        step();
        chk("after_bubble_pc", id_pc_o, 32'hBFC00108);

        stall_if = 1; stall_id = 1;
        step();
        flush = 1; cp0_excaddr = 32'hBFC00380;
        step();
        flush = 0; stall_if = 0; stall_id = 0;
        chk("flush_valid", {31'd0, id_valid_o}, 32'd0);
        chk("flush_im", {31'd0, flush_im_o}, 32'd1);
        chk("flush_iaddr", rom_bus.iaddr, 32'hBFC00380);
        step();
        chk("exc_pc", id_pc_o, 32'hBFC00380);
        chk("exc_inst", id_inst_o, 32'hE59A0380);
        chk("exc_delay", {31'd0, id_in_delay_o}, 32'd0);

        jtsel = 2'b10; jump_addr_3 = 32'hBFC00202;
        step();
        jtsel = 2'b00;
        chk("mis_ice", {31'd0, rom_bus.ice}, 32'd0);
        step();
        chk("mis_pc", id_pc_o, 32'hBFC00202);
        chk("mis_exc", {27'd0, if_exccode_o}, 32'h04);
        chk("mis_inst", id_inst_o, 32'd0);
        chk("mis_valid", {31'd0, id_valid_o}, 32'd1);
        step();
        chk("mis_advance", rom_bus.iaddr, 32'hBFC0020A);
        flush = 1; cp0_excaddr = 32'hBFC00400;
        step();
        flush = 0;
        step();
        chk("recover_pc", id_pc_o, 32'hBFC00400);

        // Reset mid-stall must empty the hold buffer.
        stall_if = 1; stall_id = 1;
        step();
        rst = 1;
        step();
        chk("rst_stall_valid", {31'd0, id_valid_o}, 32'd0);
        rst = 0; stall_if = 0; stall_id = 0;
        step();
        chk("rst_stall_inst", id_inst_o, 32'h0000083C);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
